// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU M-stage data bus: widths, I/O map and timer register layout.
package cpu_bus_pkg;

    localparam int DBITS = 32;

    localparam logic [DBITS-1:0] ADDRHEX  = 32'hFFFFF000;
    localparam logic [DBITS-1:0] ADDRLEDR = 32'hFFFFF020;
    localparam logic [DBITS-1:0] ADDRKEY  = 32'hFFFFF080;
    localparam logic [DBITS-1:0] ADDRSW   = 32'hFFFFF090;
    localparam logic [DBITS-1:0] ADDRTCNT = 32'hFFFFF100;
    localparam logic [DBITS-1:0] ADDRTLIM = 32'hFFFFF104;
    localparam logic [DBITS-1:0] ADDRTCTL = 32'hFFFFF108;

    localparam int TCTL_RDY = 0;
    localparam int TCTL_OR  = 2;
    localparam int TCTL_IE  = 8;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_TCNT,
        REG_TLIM,
        REG_TCTL
    } timer_reg_e;

    function automatic logic [DBITS-1:0] tctl_word(input logic rdy, input logic ovr, input logic ie);
        logic [DBITS-1:0] w;
        w           = '0;
        w[TCTL_RDY] = rdy;
        w[TCTL_OR]  = ovr;
        w[TCTL_IE]  = ie;
        return w;
    endfunction

endpackage

// File: rtl/timer_device_if.sv
// Data-bus view seen by the timer: CPU drives address/strobe/data, the device answers.
interface timer_device_if;
    import cpu_bus_pkg::*;

    logic [DBITS-1:0] memaddr;
    logic             wrmem;
    logic [DBITS-1:0] wmemval;
    logic [DBITS-1:0] memout;
    logic             sel;
    logic             intr;

    modport master (
        output memaddr, wrmem, wmemval,
        input  memout, sel, intr
    );

    modport slave (
        input  memaddr, wrmem, wmemval,
        output memout, sel, intr
    );

endinterface

// File: rtl/timer_device_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICKDIV clocks; clr restarts the period.
module tick_prescaler #(
    parameter int TICKDIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int              CW   = $clog2(TICKDIV);
    localparam logic [CW-1:0]   LAST = CW'(TICKDIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/timer_device.sv
// Memory-mapped millisecond timer (TCNT/TLIM/TCTL) on the M-stage data bus.
// Optional interrupt output enabled by defining TIMER_INTR_EN.
module timer_device
    import cpu_bus_pkg::*;
#(
    parameter int TICKDIV = 50000
) (
    input  logic           clk,
    input  logic           reset,
    timer_device_if.slave  bus
);

    logic [DBITS-1:0] tcnt;
    logic [DBITS-1:0] tlim;
    logic             rdy;
    logic             ovr;
    logic             ie_rd;
    timer_reg_e       hit;

    logic tick;
    logic wr_tcnt, wr_tlim, wr_tctl;
    logic wrap;
    logic clr_rdy, clr_or;

    always_comb begin
        hit = REG_NONE;
        if (bus.memaddr == ADDRTCNT)      hit = REG_TCNT;
        else if (bus.memaddr == ADDRTLIM) hit = REG_TLIM;
        else if (bus.memaddr == ADDRTCTL) hit = REG_TCTL;
    end

    assign bus.sel = (hit != REG_NONE);

    assign wr_tcnt = bus.wrmem && (hit == REG_TCNT);
    assign wr_tlim = bus.wrmem && (hit == REG_TLIM);
    assign wr_tctl = bus.wrmem && (hit == REG_TCTL);

    tick_prescaler #(
        .TICKDIV (TICKDIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (wr_tcnt || wr_tlim),
        .tick  (tick)
    );

    // A register write to TCNT/TLIM swallows a coincident tick, so no wrap can happen then.
    assign wrap = tick && !wr_tcnt && !wr_tlim &&
                  (tlim != '0) && (tcnt == tlim - DBITS'(1));

    assign clr_rdy = wr_tctl && !bus.wmemval[TCTL_RDY];
    assign clr_or  = wr_tctl && !bus.wmemval[TCTL_OR];

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt <= '0;
            tlim <= '0;
        end else if (wr_tlim) begin
            tlim <= bus.wmemval;
            tcnt <= '0;
        end else if (wr_tcnt) begin
            tcnt <= bus.wmemval;
        end else if (tick) begin
            tcnt <= wrap ? '0 : tcnt + DBITS'(1);
        end
    end

    // A wrap always wins over a software clear of RDY so the event is never lost;
    // in that case OR is not set, but an explicit OR clear still applies.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdy <= 1'b0;
            ovr <= 1'b0;
        end else begin
            if (wrap)         rdy <= 1'b1;
            else if (clr_rdy) rdy <= 1'b0;

            if (wrap && rdy && !clr_rdy) ovr <= 1'b1;
            else if (clr_or)             ovr <= 1'b0;
        end
    end

`ifdef TIMER_INTR_EN
    logic ie;
    logic intr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ie     <= 1'b0;
            intr_q <= 1'b0;
        end else begin
            if (wr_tctl) ie <= bus.wmemval[TCTL_IE];
            intr_q <= ie && rdy;
        end
    end

    assign ie_rd    = ie;
    assign bus.intr = intr_q;
`else
    assign ie_rd    = 1'b0;
    assign bus.intr = 1'b0;
`endif

    always_comb begin
        bus.memout = '0;
        unique case (hit)
            REG_TCNT: bus.memout = tcnt;
            REG_TLIM: bus.memout = tlim;
            REG_TCTL: bus.memout = tctl_word(rdy, ovr, ie_rd);
            default:  bus.memout = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_device.sv
// Bench for timer_device with TICKDIV=4: directed vector table, hand-written corner sequences,
// and randomized bus traffic compared against a behavioural model.
module tb_timer_device;
    import cpu_bus_pkg::*;

    localparam int TD = 4;
    localparam logic [31:0] ADDRBAD = 32'hFFFFF10C;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    timer_device_if bus();

    timer_device #(.TICKDIV(TD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int nvec = 0;
    int nbad = 0;

    // Behavioural model: elapsed-cycle phase within a tick period plus the three registers.
    logic [31:0] m_tcnt = 0;
    logic [31:0] m_tlim = 0;
    bit m_rdy = 0, m_or = 0, m_ie = 0, m_intr = 0;
    int m_phase = 0;

    always @(posedge clk) begin
        bit tick, wt, wl, wc, wrap, crdy, cor;
        logic [31:0] a, d;
        a = bus.memaddr;
        d = bus.wmemval;
        if (reset) begin
            m_tcnt = 0; m_tlim = 0; m_rdy = 0; m_or = 0; m_ie = 0; m_intr = 0; m_phase = 0;
        end else begin
            tick = (m_phase == TD - 1);
            m_phase = tick ? 0 : m_phase + 1;
            wt = bus.wrmem && (a == ADDRTCNT);
            wl = bus.wrmem && (a == ADDRTLIM);
            wc = bus.wrmem && (a == ADDRTCTL);
            wrap = 0;
`ifdef TIMER_INTR_EN
            m_intr = m_ie && m_rdy;
            if (wc) m_ie = d[8];
`endif
            if (wl) begin
                m_tlim = d; m_tcnt = 0; m_phase = 0;
            end else if (wt) begin
                m_tcnt = d; m_phase = 0;
            end else if (tick) begin
                if (m_tlim != 0 && m_tcnt + 1 == m_tlim) begin
                    wrap = 1; m_tcnt = 0;
                end else begin
                    m_tcnt = m_tcnt + 1;
                end
            end
            crdy = wc && !d[0];
            cor  = wc && !d[2];
            if (wrap) begin
                if (m_rdy && !crdy) m_or = 1;
                else if (cor)       m_or = 0;
                m_rdy = 1;
            end else begin
                if (crdy) m_rdy = 0;
                if (cor)  m_or = 0;
            end
        end
    end

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a == ADDRTCNT) return m_tcnt;
        if (a == ADDRTLIM) return m_tlim;
        if (a == ADDRTCTL) return {23'b0, m_ie, 5'b0, m_or, 1'b0, m_rdy};
        return 32'h0;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // All bus tasks start and end positioned just after a falling edge.
    task automatic idle(input int n);
        bus.wrmem = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.memaddr = a;
        bus.wmemval = d;
        bus.wrmem   = 1'b1;
        @(negedge clk);
        bus.wrmem   = 1'b0;
    endtask

    task automatic chk_reg(input string nm, input logic [31:0] a, input logic [31:0] exp);
        bus.memaddr = a;
        #1;
        check(nm, bus.memout, exp);
    endtask

    task automatic chk_intr(input string nm, input bit exp);
        #1;
        check(nm, {31'b0, bus.intr}, {31'b0, exp});
    endtask

    typedef struct {
        string       name;
        bit          wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        int          waitc;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    localparam logic [31:0] IE_EXP = 
`ifdef TIMER_INTR_EN
        32'h100;
`else
        32'h0;
`endif

`ifdef TIMER_INTR_EN
    localparam bit INTR_ON = 1'b1;
`else
    localparam bit INTR_ON = 1'b0;
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.memaddr = '0;
        bus.wmemval = '0;
        bus.wrmem   = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        tbl.push_back('{"rst_tcnt",      0, 0, 0, 0, ADDRTCNT, 32'h0});
        tbl.push_back('{"rst_tlim",      0, 0, 0, 0, ADDRTLIM, 32'h0});
        tbl.push_back('{"rst_tctl",      0, 0, 0, 0, ADDRTCTL, 32'h0});
        tbl.push_back('{"tcnt5_8clk",    1, ADDRTCNT, 32'd5, 8, ADDRTCNT, 32'd7});
        tbl.push_back('{"tlim3_e3",      1, ADDRTLIM, 32'd3, 3, ADDRTCNT, 32'd0});
        tbl.push_back('{"tlim3_e4",      0, 0, 0, 1, ADDRTCNT, 32'd1});
        tbl.push_back('{"tlim3_e8",      0, 0, 0, 4, ADDRTCNT, 32'd2});
        tbl.push_back('{"tctl_e11",      0, 0, 0, 3, ADDRTCTL, 32'h0});
        tbl.push_back('{"tctl_wrap_e12", 0, 0, 0, 1, ADDRTCTL, 32'h1});
        tbl.push_back('{"tcnt_wrap_e12", 0, 0, 0, 0, ADDRTCNT, 32'd0});
        tbl.push_back('{"tctl_e23",      0, 0, 0, 11, ADDRTCTL, 32'h1});
        tbl.push_back('{"tctl_or_e24",   0, 0, 0, 1, ADDRTCTL, 32'h5});
        tbl.push_back('{"tctl_clr",      1, ADDRTCTL, 32'h0, 0, ADDRTCTL, 32'h0});
        tbl.push_back('{"tctl_set_noop", 1, ADDRTCTL, 32'h1, 0, ADDRTCTL, 32'h0});
        tbl.push_back('{"tlim_hold",     0, 0, 0, 0, ADDRTLIM, 32'd3});
        tbl.push_back('{"tlim0",         1, ADDRTLIM, 32'd0, 0, ADDRTLIM, 32'd0});
        tbl.push_back('{"tcnt_modwrap",  1, ADDRTCNT, 32'hFFFFFFFF, 4, ADDRTCNT, 32'd0});
        tbl.push_back('{"tctl_nowrap0",  0, 0, 0, 0, ADDRTCTL, 32'h0});

        chk_intr("rst_intr", 1'b0);
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].wr) wr(tbl[i].waddr, tbl[i].wdata);
            idle(tbl[i].waitc);
            chk_reg(tbl[i].name, tbl[i].raddr, tbl[i].exp);
        end

        // Clear of RDY landing exactly on wrap edges, then a TCNT write on a tick edge.
        wr(ADDRTLIM, 32'd3);
        idle(11);
        wr(ADDRTCTL, 32'h0);
        chk_reg("wrap_vs_clr_rdy0", ADDRTCTL, 32'h1);
        idle(11);
        wr(ADDRTCTL, 32'h0);
        chk_reg("wrap_vs_clr_keep_or", ADDRTCTL, 32'h1);
        idle(12);
        chk_reg("wrap_sets_or", ADDRTCTL, 32'h5);
        idle(11);
        wr(ADDRTCTL, 32'h0);
        chk_reg("wrap_vs_clr_or", ADDRTCTL, 32'h1);
        idle(3);
        wr(ADDRTCNT, 32'd2);
        chk_reg("tcnt_wr_on_tick", ADDRTCNT, 32'd2);

        // Unmapped write is ignored and not decoded.
        bus.memaddr = ADDRBAD;
        bus.wmemval = 32'hFFFFFFFF;
        bus.wrmem   = 1'b1;
        #1;
        check("bad_memout", bus.memout, 32'h0);
        check("bad_sel", {31'b0, bus.sel}, 32'h0);
        @(negedge clk);
        bus.wrmem = 1'b0;
        chk_reg("bad_tlim", ADDRTLIM, 32'd3);
        chk_reg("bad_tcnt", ADDRTCNT, m_read(ADDRTCNT));
        chk_reg("bad_tctl", ADDRTCTL, 32'h1);
        check("good_sel", {31'b0, bus.sel}, 32'h1);

        idle(2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reg("midrst_tcnt", ADDRTCNT, 32'h0);
        chk_reg("midrst_tlim", ADDRTLIM, 32'h0);
        chk_reg("midrst_tctl", ADDRTCTL, 32'h0);
        chk_intr("midrst_intr", 1'b0);

        // Interrupt path (or its absence).
        wr(ADDRTLIM, 32'd2);
        wr(ADDRTCTL, 32'h100);
        idle(6);
        chk_reg("ie_tctl", ADDRTCTL, IE_EXP);
        chk_intr("intr_before", 1'b0);
        idle(1);
        chk_reg("ie_rdy_tctl", ADDRTCTL, IE_EXP | 32'h1);
        chk_intr("intr_same_cycle", 1'b0);
        idle(1);
        chk_intr("intr_rise", INTR_ON);
        wr(ADDRTCTL, 32'h100);
        chk_intr("intr_hold", INTR_ON);
        idle(1);
        chk_intr("intr_fall", 1'b0);
        chk_reg("ie_after_clr", ADDRTCTL, IE_EXP);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            int r, s;
            logic [31:0] a;
            r = $urandom_range(0, 99);
            s = $urandom_range(0, 4);
            a = (s == 0) ? ADDRTCNT : (s == 1) ? ADDRTLIM : (s == 2) ? ADDRTCTL :
                (s == 3) ? ADDRBAD : ($urandom | 32'h1);
            reset       = (r < 2);
            bus.memaddr = a;
            bus.wrmem   = (r >= 2 && r < 22);
            bus.wmemval = (s == 0) ? 32'($urandom_range(0, 5)) :
                          (s == 1) ? 32'($urandom_range(0, 4)) : $urandom;
            #1;
            check("rnd_memout", bus.memout, m_read(a));
            check("rnd_sel", {31'b0, bus.sel},
                  {31'b0, (a == ADDRTCNT || a == ADDRTLIM || a == ADDRTCTL)});
            check("rnd_intr", {31'b0, bus.intr}, {31'b0, m_intr});
            @(negedge clk);
        end
        reset     = 1'b0;
        bus.wrmem = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
